// File: rtl/ser2par.sv
// Serial-to-parallel collector: WIDTH-bit words onto a one-entry valid/ready output register, with sticky ovf/perr flags.
// Optional even-parity bit after each word is enabled by defining SER2PAR_PARITY_EN.
module ser2par #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sin_vld,
  input  logic                         sin,
  input  logic                         sin_clr,
  output logic [WIDTH-1:0]             dout,
  output logic                         dout_vld,
  input  logic                         dout_rdy,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
  output logic                         ovf,
  output logic                         perr
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH-1);

`ifdef SER2PAR_PARITY_EN
  typedef enum logic {ST_COLLECT, ST_PARITY} state_e;
`else
  typedef enum logic {ST_COLLECT} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] word_dat;
  logic             word_done;
`ifdef SER2PAR_PARITY_EN
  logic             perr_q, perr_d;
  logic             par_bad;
`endif

  assign shift_nxt = MSB_FIRST ? {sr_q[WIDTH-2:0], sin} : {sin, sr_q[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_COLLECT;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (sin_clr) begin
      state_d = ST_COLLECT;
    end
`ifdef SER2PAR_PARITY_EN
    else if (sin_vld) begin
      case (state_q)
        ST_COLLECT: if (cnt_q == LAST_IDX) state_d = ST_PARITY;
        ST_PARITY:  state_d = ST_COLLECT;
        default:    state_d = ST_COLLECT;
      endcase
    end
`endif
  end

  // Collection datapath: produces a completed word strobe and its contents
  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    word_dat  = shift_nxt;
`ifdef SER2PAR_PARITY_EN
    par_bad   = 1'b0;
`endif
    if (sin_clr) begin
      cnt_d = '0;
    end else if (sin_vld) begin
      if (state_q == ST_COLLECT) begin
        sr_d = shift_nxt;
        if (cnt_q == LAST_IDX) begin
`ifdef SER2PAR_PARITY_EN
          cnt_d = CW'(WIDTH);
`else
          cnt_d     = '0;
          word_done = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef SER2PAR_PARITY_EN
      else begin
        // sr_q holds the full data word; sin is the parity bit
        cnt_d    = '0;
        word_dat = sr_q;
        if (^{sr_q, sin}) par_bad = 1'b1;
        else              word_done = 1'b1;
      end
`endif
    end
  end

  // Output register and sticky flags
  always_comb begin
    dout_d = dout_q;
    vld_d  = vld_q & ~dout_rdy;
    ovf_d  = sin_clr ? 1'b0 : ovf_q;
`ifdef SER2PAR_PARITY_EN
    perr_d = sin_clr ? 1'b0 : (perr_q | par_bad);
`endif
    if (word_done) begin
      if (!vld_q || dout_rdy) begin
        dout_d = word_dat;
        vld_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef SER2PAR_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
`ifdef SER2PAR_PARITY_EN
      perr_q <= perr_d;
`endif
    end
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign bit_cnt  = cnt_q;
  assign ovf      = ovf_q;
`ifdef SER2PAR_PARITY_EN
  assign perr     = perr_q;
`else
  assign perr     = 1'b0;
`endif

endmodule

// File: tb/tb_ser2par.sv
// Directed bench for ser2par: MSB-first and LSB-first instances share one stimulus table.
module tb_ser2par;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sin_vld = 1'b0;
  logic       sin = 1'b0;
  logic       sin_clr = 1'b0;
  logic       dout_rdy = 1'b1;

  logic [7:0] dout_m, dout_l;
  logic       vld_m, vld_l;
  logic [3:0] cnt_m, cnt_l;
  logic       ovf_m, ovf_l;
  logic       perr_m, perr_l;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ser2par #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .sin_vld(sin_vld), .sin(sin), .sin_clr(sin_clr),
    .dout(dout_m), .dout_vld(vld_m), .dout_rdy(dout_rdy),
    .bit_cnt(cnt_m), .ovf(ovf_m), .perr(perr_m)
  );

  ser2par #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sin_vld(sin_vld), .sin(sin), .sin_clr(sin_clr),
    .dout(dout_l), .dout_vld(vld_l), .dout_rdy(dout_rdy),
    .bit_cnt(cnt_l), .ovf(ovf_l), .perr(perr_l)
  );

  typedef struct {
    logic       clr, vld, sin, rdy;
    logic [7:0] dm, dl;
    logic       ev;
    logic [3:0] ec;
    logic       eo;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic clr, input logic vld, input logic s, input logic rdy,
                              input logic [7:0] dm, input logic [7:0] dl,
                              input logic ev, input logic [3:0] ec, input logic eo);
    vec_t v;
    v.clr = clr; v.vld = vld; v.sin = s; v.rdy = rdy;
    v.dm = dm; v.dl = dl; v.ev = ev; v.ec = ec; v.eo = eo;
    vt.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
`ifndef SER2PAR_PARITY_EN
    // 8'hA5 = 1,0,1,0,0,1,0,1 ; palindromic so both orders give A5
    add(0,1,1,1, 8'h00,8'h00, 0,1,0);
    add(0,1,0,1, 8'h00,8'h00, 0,2,0);
    add(0,1,1,1, 8'h00,8'h00, 0,3,0);
    add(0,1,0,1, 8'h00,8'h00, 0,4,0);
    add(0,1,0,1, 8'h00,8'h00, 0,5,0);
    add(0,1,1,1, 8'h00,8'h00, 0,6,0);
    add(0,1,0,1, 8'h00,8'h00, 0,7,0);
    add(0,1,1,1, 8'hA5,8'hA5, 1,0,0);
    add(0,0,0,1, 8'hA5,8'hA5, 0,0,0);
    // 1,1,0,0,0,0,0,0 -> C0 msb-first, 03 lsb-first
    add(0,1,1,1, 8'hA5,8'hA5, 0,1,0);
    add(0,1,1,1, 8'hA5,8'hA5, 0,2,0);
    add(0,1,0,1, 8'hA5,8'hA5, 0,3,0);
    add(0,1,0,1, 8'hA5,8'hA5, 0,4,0);
    add(0,1,0,1, 8'hA5,8'hA5, 0,5,0);
    add(0,1,0,1, 8'hA5,8'hA5, 0,6,0);
    add(0,1,0,1, 8'hA5,8'hA5, 0,7,0);
    add(0,1,0,1, 8'hC0,8'h03, 1,0,0);
    add(0,0,0,1, 8'hC0,8'h03, 0,0,0);
    // rdy=0: 3C (0,0,1,1,1,1,0,0) delivered, then FF dropped -> ovf
    add(0,1,0,0, 8'hC0,8'h03, 0,1,0);
    add(0,1,0,0, 8'hC0,8'h03, 0,2,0);
    add(0,1,1,0, 8'hC0,8'h03, 0,3,0);
    add(0,1,1,0, 8'hC0,8'h03, 0,4,0);
    add(0,1,1,0, 8'hC0,8'h03, 0,5,0);
    add(0,1,1,0, 8'hC0,8'h03, 0,6,0);
    add(0,1,0,0, 8'hC0,8'h03, 0,7,0);
    add(0,1,0,0, 8'h3C,8'h3C, 1,0,0);
    add(0,1,1,0, 8'h3C,8'h3C, 1,1,0);
    add(0,1,1,0, 8'h3C,8'h3C, 1,2,0);
    add(0,1,1,0, 8'h3C,8'h3C, 1,3,0);
    add(0,1,1,0, 8'h3C,8'h3C, 1,4,0);
    add(0,1,1,0, 8'h3C,8'h3C, 1,5,0);
    add(0,1,1,0, 8'h3C,8'h3C, 1,6,0);
    add(0,1,1,0, 8'h3C,8'h3C, 1,7,0);
    add(0,1,1,0, 8'h3C,8'h3C, 1,0,1);
    add(0,0,0,1, 8'h3C,8'h3C, 0,0,1);
    add(1,0,0,1, 8'h3C,8'h3C, 0,0,0);
    // 5 bits, then clr with vld: bit discarded
    add(0,1,1,1, 8'h3C,8'h3C, 0,1,0);
    add(0,1,1,1, 8'h3C,8'h3C, 0,2,0);
    add(0,1,1,1, 8'h3C,8'h3C, 0,3,0);
    add(0,1,1,1, 8'h3C,8'h3C, 0,4,0);
    add(0,1,1,1, 8'h3C,8'h3C, 0,5,0);
    add(1,1,1,1, 8'h3C,8'h3C, 0,0,0);
    // 81 = 1,0,0,0,0,0,0,1
    add(0,1,1,1, 8'h3C,8'h3C, 0,1,0);
    add(0,1,0,1, 8'h3C,8'h3C, 0,2,0);
    add(0,1,0,1, 8'h3C,8'h3C, 0,3,0);
    add(0,1,0,1, 8'h3C,8'h3C, 0,4,0);
    add(0,1,0,1, 8'h3C,8'h3C, 0,5,0);
    add(0,1,0,1, 8'h3C,8'h3C, 0,6,0);
    add(0,1,0,1, 8'h3C,8'h3C, 0,7,0);
    add(0,1,1,1, 8'h81,8'h81, 1,0,0);
    // 0F while 81 waits; accept and reload on the same edge
    add(0,1,0,0, 8'h81,8'h81, 1,1,0);
    add(0,1,0,0, 8'h81,8'h81, 1,2,0);
    add(0,1,0,0, 8'h81,8'h81, 1,3,0);
    add(0,1,0,0, 8'h81,8'h81, 1,4,0);
    add(0,1,1,0, 8'h81,8'h81, 1,5,0);
    add(0,1,1,0, 8'h81,8'h81, 1,6,0);
    add(0,1,1,0, 8'h81,8'h81, 1,7,0);
    add(0,1,1,1, 8'h0F,8'hF0, 1,0,0);
    add(0,0,0,1, 8'h0F,8'hF0, 0,0,0);
`else
    // A5 + parity 0 -> delivered; A5 + parity 1 -> rejected
    add(0,1,1,1, 8'h00,8'h00, 0,1,0);
    add(0,1,0,1, 8'h00,8'h00, 0,2,0);
    add(0,1,1,1, 8'h00,8'h00, 0,3,0);
    add(0,1,0,1, 8'h00,8'h00, 0,4,0);
    add(0,1,0,1, 8'h00,8'h00, 0,5,0);
    add(0,1,1,1, 8'h00,8'h00, 0,6,0);
    add(0,1,0,1, 8'h00,8'h00, 0,7,0);
    add(0,1,1,1, 8'h00,8'h00, 0,8,0);
    add(0,1,0,1, 8'hA5,8'hA5, 1,0,0);
    add(0,0,0,1, 8'hA5,8'hA5, 0,0,0);
    add(0,1,1,1, 8'hA5,8'hA5, 0,1,0);
    add(0,1,0,1, 8'hA5,8'hA5, 0,2,0);
    add(0,1,1,1, 8'hA5,8'hA5, 0,3,0);
    add(0,1,0,1, 8'hA5,8'hA5, 0,4,0);
    add(0,1,0,1, 8'hA5,8'hA5, 0,5,0);
    add(0,1,1,1, 8'hA5,8'hA5, 0,6,0);
    add(0,1,0,1, 8'hA5,8'hA5, 0,7,0);
    add(0,1,1,1, 8'hA5,8'hA5, 0,8,0);
    add(0,1,1,1, 8'hA5,8'hA5, 0,0,0);
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset dout_msb", 32'(dout_m), 32'h0);
    check("reset dout_vld", 32'(vld_m), 32'h0);
    check("reset bit_cnt",  32'(cnt_m), 32'h0);
    check("reset ovf",      32'(ovf_m), 32'h0);
    check("reset perr",     32'(perr_m), 32'h0);
    rst = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      sin_clr  = vt[i].clr;
      sin_vld  = vt[i].vld;
      sin      = vt[i].sin;
      dout_rdy = vt[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("row%0d dout_msb", i), 32'(dout_m), 32'(vt[i].dm));
      check($sformatf("row%0d dout_lsb", i), 32'(dout_l), 32'(vt[i].dl));
      check($sformatf("row%0d dout_vld", i), 32'(vld_m),  32'(vt[i].ev));
      check($sformatf("row%0d vld_lsb", i),  32'(vld_l),  32'(vt[i].ev));
      check($sformatf("row%0d bit_cnt", i),  32'(cnt_m),  32'(vt[i].ec));
      check($sformatf("row%0d ovf", i),      32'(ovf_m),  32'(vt[i].eo));
    end
    sin_clr = 1'b0;
    sin_vld = 1'b0;
    dout_rdy = 1'b1;

`ifdef SER2PAR_PARITY_EN
    check("parity perr", 32'(perr_m), 32'h1);
    check("parity ovf",  32'(ovf_m),  32'h0);
    sin_clr = 1'b1;
    @(posedge clk);
    #1;
    sin_clr = 1'b0;
    check("clr perr", 32'(perr_m), 32'h0);
`else
    check("noparity perr", 32'(perr_m), 32'h0);
`endif

    // Asynchronous reset mid-word, between clock edges
    for (int b = 0; b < 3; b++) begin
      sin_vld = 1'b1;
      sin     = 1'b1;
      @(posedge clk);
      #1;
    end
    sin_vld = 1'b0;
    check("pre-reset bit_cnt", 32'(cnt_m), 32'h3);
    #2;
    rst = 1'b0;
    #1;
    check("async dout_msb", 32'(dout_m), 32'h0);
    check("async dout_lsb", 32'(dout_l), 32'h0);
    check("async dout_vld", 32'(vld_m),  32'h0);
    check("async bit_cnt",  32'(cnt_m),  32'h0);
    check("async bit_cnt_lsb", 32'(cnt_l), 32'h0);
    check("async ovf",      32'(ovf_m | ovf_l),  32'h0);
    check("async perr",     32'(perr_m | perr_l), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset bit_cnt", 32'(cnt_m), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
